crc_framer: RTL

Byte-stream CRC-16-CCITT framer.
- Sits between a packet source and the serial/link transmit path.
- Passes each frame's payload bytes through unchanged, running a byte-parallel CRC over them.
- After the last payload byte, appends the two CRC bytes, high byte first.
- Owns the CRC state: initialises it per frame, advances it one byte per accepted beat, and enforces a maximum frame length.

---
 rtl/crc_framer.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/crc_framer.sv
// Byte-stream CRC-16-CCITT framer: passes payload through and appends the CRC, high byte first.
// Optional completed-frame counter enabled with CRC_FRAMER_STATS_EN.
module crc_framer #(
  parameter int          MAX_LEN  = 1024,
  parameter logic [15:0] CRC_INIT = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic [7:0]  m_data,
  output logic        m_valid,
  output logic        m_last,
  input  logic        m_ready,
  output logic        err_long,
  output logic [15:0] frame_count
);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    CRC_HI,
    CRC_LO
  } state_t;

  localparam logic [15:0] MAX_LEN16 = 16'(MAX_LEN);

  state_t      state;
  state_t      state_n;
  logic [15:0] crc;
  logic [15:0] crc_n;
  logic [15:0] len;
  logic [15:0] len_n;
  logic        can_load;
  logic        load;
  logic [7:0]  load_data;
  logic        load_last;
  logic        err_n;

  // MSB-first polynomial 0x1021, one byte folded in as eight unrolled shift/XOR steps
  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {d, 8'h00};
    for (int i = 0; i < 8; i++) begin
      r = r[15] ? ({r[14:0], 1'b0} ^ 16'h1021) : {r[14:0], 1'b0};
    end
    return r;
  endfunction

  assign can_load = !m_valid || m_ready;
  assign s_ready  = !reset && ((state == IDLE) || (state == DATA)) && can_load;

  always_comb begin
    state_n   = state;
    crc_n     = crc;
    len_n     = len;
    load      = 1'b0;
    load_data = 8'h00;
    load_last = 1'b0;
    err_n     = 1'b0;
    case (state)
      IDLE, DATA: begin
        if (s_valid && s_ready) begin
          load      = 1'b1;
          load_data = s_data;
          crc_n     = crc_step(crc, s_data);
          len_n     = (state == IDLE) ? 16'd1 : len + 16'd1;
          // Hitting MAX_LEN without s_last closes the frame early and flags it
          if (s_last || (len_n == MAX_LEN16)) begin
            state_n = CRC_HI;
            err_n   = !s_last;
          end else begin
            state_n = DATA;
          end
        end
      end
      CRC_HI: begin
        if (can_load) begin
          load      = 1'b1;
          load_data = crc[15:8];
          state_n   = CRC_LO;
        end
      end
      CRC_LO: begin
        if (can_load) begin
          load      = 1'b1;
          load_data = crc[7:0];
          load_last = 1'b1;
          state_n   = IDLE;
          crc_n     = CRC_INIT;
          len_n     = 16'd0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // The output register drains on m_ready and reloads in the same cycle without a bubble
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      crc      <= CRC_INIT;
      len      <= 16'd0;
      m_valid  <= 1'b0;
      m_data   <= 8'h00;
      m_last   <= 1'b0;
      err_long <= 1'b0;
    end else begin
      state    <= state_n;
      crc      <= crc_n;
      len      <= len_n;
      err_long <= err_n;
      if (load) begin
        m_valid <= 1'b1;
        m_data  <= load_data;
        m_last  <= load_last;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

`ifdef CRC_FRAMER_STATS_EN
  logic [15:0] frame_count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_count_q <= 16'd0;
    end else if ((state == CRC_LO) && can_load) begin
      frame_count_q <= frame_count_q + 16'd1;
    end
  end

  assign frame_count = frame_count_q;
`else
  assign frame_count = 16'd0;
`endif

endmodule
